lsu_dmem_ctrl: RTL and testbench
================================

# lsu_dmem_ctrl

Load/store unit between the RISC-V core's execute stage and a word-wide data memory that uses a valid/ready handshake. It accepts one load or store per request, generates byte enables and lane-replicated store data, sign- or zero-extends load data, and detects misaligned accesses, illegal width codes and bus timeouts. It drives a stall output that holds the PC while the access is outstanding. This lets the core run against a data memory with wait states instead of the combinational-read RAM.

## Interface
- TIMEOUT, 255: number of cycles spent in BUS without mem_ready before the access is aborted with err.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  core presents a load or store this cycle; held until done.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access width/sign code taken from the instruction.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2), right-aligned.
- stall  out  1  hold PC/pipeline; equals req_valid & ~done.
- done  out  1  one-cycle pulse: the access has finished, or has faulted.
- rdata  out  32  extended load data; valid while done=1.
- misaligned  out  1  with done, the access faulted on alignment.
- err  out  1  with done, the access faulted on an illegal funct3 or a timeout.
- mem_valid  out  1  bus request.
- mem_ready  in  1  memory accepts the request and returns data this cycle.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address; bits [1:0] are forced to 00.
- mem_be  out  4  byte enables; bit i selects byte lane i.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; sampled only when mem_valid & mem_ready.

## Operation
- State machine with states IDLE, BUS, RESP and FAULT. State resets to IDLE.
- **IDLE**
  - If req_valid is high and the request is legal and aligned: latch we, funct3, addr and the lane-formatted wdata/be, clear the timeout counter, go to BUS.
  - If req_valid is high and the request is misaligned or illegal: go to FAULT.
- **BUS**
  - mem_valid=1. mem_addr, mem_we, mem_be and mem_wdata come from the latched values and stay stable.
  - If mem_ready is high: capture mem_rdata, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to FAULT with err.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins.
- **RESP**: done=1 and rdata is valid; go to IDLE.
- **FAULT**: done=1, rdata=0, and misaligned or err is asserted, each as a 1-cycle pulse; go to IDLE. The core must suppress the register write on a fault.
- **Legal funct3 codes**
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code sets err.
- **Alignment**: halfword accesses require addr[0]=0; word accesses require addr[1:0]=00. A violation sets misaligned.
- **Byte enables**: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. mem_be is driven for loads too, with mem_we=0.
- **Store data**: sb drives {4{wdata[7:0]}}; sh drives {2{wdata[15:0]}}; sw passes wdata through.
- **Load data**
  - Select the byte or half from the captured word using the latched addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- mem_ready is ignored outside BUS.
- Deasserting req_valid during BUS does not abort the bus cycle. The access completes, and done still pulses.
- Exactly one bus transaction per accepted request; no pipelining.

## Timing
- Reset asynchronously forces state=IDLE and the timeout counter to 0. It forces done, misaligned, err, mem_valid, mem_we and mem_be to 0, and rdata, mem_addr and mem_wdata to 0. An in-flight transaction is dropped: mem_valid falls immediately and no done is issued.
- **Minimum latency** is 3 cycles from req_valid: IDLE (accept), BUS (mem_ready=1), RESP (done). stall is 1 in the first two cycles and 0 in the RESP cycle, so the PC advances on the edge that ends RESP.
- **Wait states**: each cycle with mem_ready=0 in BUS adds one cycle.
- **Fault latency**: a misaligned or illegal request reaches FAULT in 2 cycles. A timeout gives done in cycle TIMEOUT+3 after acceptance.
- done, rdata, misaligned and err are registered outputs, driven from state. stall is combinational from req_valid and done.
- A new request may be accepted in the IDLE cycle immediately after RESP or FAULT.

## Test plan
- **lw, no wait states**: lw at 0x64 with mem_rdata=0x00000019 and mem_ready=1 in BUS -> mem_addr=0x64, mem_be=1111, done in cycle 3, rdata=0x00000019, stall high for 2 cycles.
- **lb / lbu**: lb at 0x63 with mem_rdata=0x80FF7F01 -> mem_be=1000, rdata=0xFFFFFF80; lbu at the same address -> rdata=0x00000080.
- **sh with wait states**: sh at 0x62 with wdata=0x1234ABCD and mem_ready low for 3 BUS cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held stable for 4 BUS cycles, done in cycle 6.
- **Faults**: lw at 0x66 -> no mem_valid, done with misaligned=1 in cycle 2; funct3=011 -> done with err=1.
- **Timeout**: TIMEOUT=4 and mem_ready held low -> done with err=1 in cycle 7; a following lw completes normally.
- **Reset mid-operation**: reset asserted during BUS -> mem_valid falls immediately, no done; after release, a new sw at 0x60 completes in 3 cycles.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between execute and a valid/ready word-wide data memory:
// lane-formats stores, extends loads, reports alignment/encoding/timeout faults.

module lsu_lane #(
   parameter int VEC_W = 8,
   parameter int LANE  = 0
) (
   input  logic [1:0]       size,
   input  logic [1:0]       offs,
   input  logic [VEC_W-1:0] b_src,
   input  logic [VEC_W-1:0] h_src,
   input  logic [VEC_W-1:0] w_src,
   output logic             be,
   output logic [VEC_W-1:0] wb
);
   localparam logic [1:0] LID = 2'(LANE);

   always_comb begin
      be = 1'b1;
      wb = w_src;
      case (size)
         2'd0: begin be = (offs == LID);       wb = b_src; end
         2'd1: begin be = (offs[1] == LID[1]); wb = h_src; end
         default: ;
      endcase
   end
endmodule

module lsu_dmem_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;
   localparam int CW        = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;

   typedef struct packed {
      logic                            we;
      logic [2:0]                      funct3;
      logic [31:0]                     addr;
      logic [NUM_LANES-1:0]            be;
      logic [NUM_LANES-1:0][VEC_W-1:0] wdata;
   } lsu_req_t;

   state_t   state, nxt;
   lsu_req_t lat;
   logic [CW-1:0] cnt;
   logic done_q, mis_q, err_q, nxt_mis, nxt_err;
   logic [31:0] rdata_q, ld_ext, sh_word;
   logic legal, misal, accept;
   logic [NUM_LANES-1:0]            fmt_be;
   logic [NUM_LANES-1:0][VEC_W-1:0] fmt_wdata;

   // Lane formatting happens on the request side so the bus sees latched, stable values.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lsu_lane #(.VEC_W(VEC_W), .LANE(i)) u_lane (
         .size (req_funct3[1:0]),
         .offs (req_addr[1:0]),
         .b_src(req_wdata[VEC_W-1:0]),
         .h_src(req_wdata[VEC_W*(i%2) +: VEC_W]),
         .w_src(req_wdata[VEC_W*i +: VEC_W]),
         .be   (fmt_be[i]),
         .wb   (fmt_wdata[i])
      );
   end

   always_comb begin
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~req_we;
         default:                legal = 1'b0;
      endcase
      misal = ((req_funct3[1:0] == 2'd1) & req_addr[0]) |
              ((req_funct3[1:0] == 2'd2) & (|req_addr[1:0]));
   end

   assign accept = (state == IDLE) & req_valid & legal & ~misal;

   assign sh_word = mem_rdata >> {lat.addr[1:0], 3'b000};

   always_comb begin
      case (lat.funct3)
         3'b000:  ld_ext = {{24{sh_word[7]}}, sh_word[7:0]};
         3'b001:  ld_ext = {{16{sh_word[15]}}, sh_word[15:0]};
         3'b010:  ld_ext = sh_word;
         3'b100:  ld_ext = {24'b0, sh_word[7:0]};
         3'b101:  ld_ext = {16'b0, sh_word[15:0]};
         default: ld_ext = '0;
      endcase
   end

   // An encoding fault takes priority over alignment; mem_ready beats the timeout.
   always_comb begin
      nxt     = state;
      nxt_mis = 1'b0;
      nxt_err = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            if (!legal) begin
               nxt = FAULT; nxt_err = 1'b1;
            end else if (misal) begin
               nxt = FAULT; nxt_mis = 1'b1;
            end else begin
               nxt = BUS;
            end
         end
         BUS: if (mem_ready) begin
            nxt = RESP;
         end else if (cnt == CW'(TIMEOUT)) begin
            nxt = FAULT; nxt_err = 1'b1;
         end
         RESP:    nxt = IDLE;
         FAULT:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         lat     <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state   <= nxt;
         done_q  <= (nxt == RESP) || (nxt == FAULT);
         mis_q   <= nxt_mis;
         err_q   <= nxt_err;
         rdata_q <= (state == BUS && mem_ready && !lat.we) ? ld_ext : '0;
         if (state == IDLE)
            cnt <= '0;
         else if (state == BUS && !mem_ready)
            cnt <= cnt + CW'(1);
         if (accept) begin
            lat.we     <= req_we;
            lat.funct3 <= req_funct3;
            lat.addr   <= req_addr;
            lat.be     <= fmt_be;
            lat.wdata  <= fmt_wdata;
         end
      end
   end

   assign stall      = req_valid & ~done_q;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign misaligned = mis_q;
   assign err        = err_q;
   assign mem_valid  = (state == BUS);
   assign mem_we     = lat.we;
   assign mem_addr   = {lat.addr[31:2], 2'b00};
   assign mem_be     = lat.be;
   assign mem_wdata  = lat.wdata;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl: per-request behavioural model, per-cycle
// compare process, and literal expectations from hand-worked accesses.

module tb_lsu_dmem_ctrl;
   localparam int TO = 4;

   logic clk = 1'b0, reset = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic stall, done, misaligned, err, mem_valid, mem_we;
   logic mem_ready = 1'b0;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  mem_be;

   lsu_dmem_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned), .err(err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int ncyc = 0, t_start = 0, cur_waits = 0;
   bit in_txn = 1'b0, skip = 1'b0;

   logic exp_bus, exp_mis, exp_err, exp_we;
   logic [3:0]  exp_be;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   int exp_done;

   int got_done, bus_n, stall_n;
   logic got_mis, got_err, got_we;
   logic [3:0]  got_be;
   logic [31:0] got_rdata, got_wdata, got_addr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) ncyc <= ncyc + 1;

   // Memory: ready after cur_waits BUS cycles; ready held high outside BUS.
   initial begin
      int bw;
      bw = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_valid) begin
            mem_ready = (bw == cur_waits);
            bw++;
         end else begin
            bw = 0;
            mem_ready = 1'b1;
         end
      end
   end

   // Compare process
   initial begin
      int cur;
      forever begin
         @(negedge clk);
         if (!reset && !skip) begin
            chk("stall", 32'(stall), 32'(req_valid & ~done));
            if (in_txn) begin
               cur = ncyc - t_start + 1;
               chk("mem_valid", 32'(mem_valid), 32'(exp_bus && cur >= 2 && cur < exp_done));
               if (mem_valid) begin
                  chk("mem_addr", mem_addr, exp_addr);
                  chk("mem_be", 32'(mem_be), 32'(exp_be));
                  chk("mem_we", 32'(mem_we), 32'(exp_we));
                  if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                  bus_n++;
                  got_be = mem_be; got_wdata = mem_wdata; got_we = mem_we; got_addr = mem_addr;
               end
               if (stall) stall_n++;
               chk("done", 32'(done), 32'(cur == exp_done));
               if (done) begin
                  got_done = cur; got_rdata = rdata; got_mis = misaligned; got_err = err;
                  chk("misaligned", 32'(misaligned), 32'(exp_mis));
                  chk("err", 32'(err), 32'(exp_err));
                  if (exp_mis || exp_err) chk("fault_rdata", rdata, 32'h0);
                  else if (!exp_we) chk("rdata", rdata, exp_rdata);
               end else begin
                  chk("mis_nodone", 32'(misaligned), 32'h0);
                  chk("err_nodone", 32'(err), 32'h0);
               end
            end else begin
               chk("idle_valid", 32'(mem_valid), 32'h0);
               chk("idle_done", 32'(done), 32'h0);
            end
         end
      end
   end

   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rw, input int waits, input bit drop);
      int bytes;
      bit legal, found;
      logic [31:0] mask, v;
      bytes = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      exp_we   = we;
      exp_mis  = legal && ((addr % bytes) != 0);
      exp_bus  = legal && !exp_mis;
      exp_err  = !legal || (exp_bus && waits > TO);
      exp_addr = addr & ~32'h3;
      exp_be   = 4'(((1 << bytes) - 1) << addr[1:0]);
      for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = wd[8*(i % bytes) +: 8];
      v = rw >> (8 * addr[1:0]);
      mask = (bytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 32'h1);
      v = v & mask;
      if (!f3[2] && bytes < 4 && v[8*bytes-1]) v = v | ~mask;
      exp_rdata = v;
      exp_done  = !exp_bus ? 2 : (waits > TO ? TO + 3 : 3 + waits);
      got_done = 0; bus_n = 0; stall_n = 0; got_mis = 0; got_err = 0; got_we = 0;
      got_be = '0; got_rdata = '0; got_wdata = '0; got_addr = '0;
      cur_waits = waits; mem_rdata = rw;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1; t_start = ncyc; in_txn = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (done) found = 1'b1;
         else begin
            @(posedge clk); #1;
            if (drop) req_valid = 1'b0;
         end
      end
      if (!found) begin
         n_chk++; n_fail++;
         $display("FAIL done_wait: no done within 50 cycles for addr %h", addr);
      end
      @(posedge clk); #1;
      in_txn = 1'b0; req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      #2;
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_mis", 32'(misaligned), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_valid", 32'(mem_valid), 32'h0);
      chk("rst_we", 32'(mem_we), 32'h0);
      chk("rst_be", 32'(mem_be), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      run(0, 3'b010, 32'h64, 32'h0, 32'h0000_0019, 0, 0);
      chk("lw_rdata_lit", got_rdata, 32'h19);
      chk("lw_be_lit", 32'(got_be), 32'hF);
      chk("lw_addr_lit", got_addr, 32'h64);
      chk("lw_done_lit", got_done, 3);
      chk("lw_stall_lit", stall_n, 2);

      run(0, 3'b000, 32'h63, 32'h0, 32'h80FF_7F01, 0, 0);
      chk("lb_rdata_lit", got_rdata, 32'hFFFF_FF80);
      chk("lb_be_lit", 32'(got_be), 32'h8);
      run(0, 3'b100, 32'h63, 32'h0, 32'h80FF_7F01, 0, 0);
      chk("lbu_rdata_lit", got_rdata, 32'h0000_0080);

      run(1, 3'b001, 32'h62, 32'h1234_ABCD, 32'h0, 3, 0);
      chk("sh_we_lit", 32'(got_we), 32'h1);
      chk("sh_be_lit", 32'(got_be), 32'hC);
      chk("sh_wdata_lit", got_wdata, 32'hABCD_ABCD);
      chk("sh_bus_lit", bus_n, 4);
      chk("sh_done_lit", got_done, 6);

      run(0, 3'b010, 32'h66, 32'h0, 32'h0, 0, 0);
      chk("mis_flag_lit", 32'(got_mis), 32'h1);
      chk("mis_done_lit", got_done, 2);
      chk("mis_bus_lit", bus_n, 0);
      run(0, 3'b011, 32'h64, 32'h0, 32'h0, 0, 0);
      chk("ill_err_lit", 32'(got_err), 32'h1);

      run(0, 3'b010, 32'h68, 32'h0, 32'h5555_AAAA, 99, 0);
      chk("to_err_lit", 32'(got_err), 32'h1);
      chk("to_done_lit", got_done, 7);
      run(0, 3'b010, 32'h6C, 32'h0, 32'hDEAD_BEEF, 0, 0);
      chk("after_to_lit", got_rdata, 32'hDEAD_BEEF);

      // ready in the very cycle the counter hits TIMEOUT: the access completes
      run(1, 3'b010, 32'h60, 32'hCAFE_F00D, 32'h0, TO, 0);
      chk("edge_err_lit", 32'(got_err), 32'h0);
      chk("edge_done_lit", got_done, TO + 3);

      run(0, 3'b001, 32'h62, 32'h0, 32'h8001_7FFF, 1, 0);
      chk("lh_rdata_lit", got_rdata, 32'hFFFF_8001);
      run(0, 3'b101, 32'h62, 32'h0, 32'h8001_7FFF, 0, 0);
      run(0, 3'b001, 32'h60, 32'h0, 32'h8001_7FFF, 2, 0);
      run(0, 3'b000, 32'h61, 32'h0, 32'h1234_F6C3, 0, 0);
      run(1, 3'b000, 32'h61, 32'h0000_00A5, 32'h0, 0, 0);
      chk("sb_wdata_lit", got_wdata, 32'hA5A5_A5A5);
      chk("sb_be_lit", 32'(got_be), 32'h2);
      run(1, 3'b100, 32'h60, 32'h1, 32'h0, 0, 0);
      run(0, 3'b001, 32'h63, 32'h0, 32'h0, 0, 0);
      run(1, 3'b001, 32'h61, 32'h0, 32'h0, 0, 0);
      run(1, 3'b010, 32'h62, 32'h0, 32'h0, 0, 0);
      run(0, 3'b111, 32'h61, 32'h0, 32'h0, 0, 0);
      run(0, 3'b010, 32'h70, 32'h0, 32'h0BAD_F00D, 2, 1);
      chk("drop_done_lit", got_done, 5);

      // reset in the middle of a bus cycle
      skip = 1'b1;
      cur_waits = 100; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h74; req_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_pre", 32'(mem_valid), 32'h1);
      #2 reset = 1'b1; req_valid = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(mem_valid), 32'h0);
      chk("rst_mid_done", 32'(done), 32'h0);
      chk("rst_mid_be", 32'(mem_be), 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      skip = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(done), 32'h0);
      end
      @(posedge clk); #1;
      run(1, 3'b010, 32'h60, 32'h1357_9BDF, 32'h0, 0, 0);
      chk("post_rst_sw_lit", got_done, 3);
      chk("post_rst_wdata_lit", got_wdata, 32'h1357_9BDF);

      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
